// File: rtl/uart_mmio.sv
// Memory-mapped 8N1 UART for the RV32I data bus: DATA/STATUS/DIV registers,
// TX and RX byte FIFOs, runtime baud divisor and combinational read data.

module uart_mmio_fifo #(
  parameter int DEPTH = 4
) (
  input  logic       clk,
  input  logic       n_rst,
  input  logic       i_push,
  input  logic       i_pop,
  input  logic [7:0] i_data,
  output logic [7:0] o_data,
  output logic       o_empty,
  output logic       o_full
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [7:0]    r_mem [DEPTH];
  logic [AW-1:0] r_wptr;
  logic [AW-1:0] r_rptr;
  logic [AW:0]   r_cnt;
  logic          w_do_push;
  logic          w_do_pop;

  assign o_empty   = (r_cnt == '0);
  assign o_full    = (r_cnt == FULL_CNT);
  assign o_data    = r_mem[r_rptr];
  assign w_do_pop  = i_pop && !o_empty;
  // A push into a full FIFO is accepted when a pop frees the head slot on the same edge.
  assign w_do_push = i_push && (!o_full || w_do_pop);

  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wptr] <= i_data;
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_wptr <= '0;
      r_rptr <= '0;
      r_cnt  <= '0;
    end else begin
      if (w_do_push) r_wptr <= r_wptr + AW'(1);
      if (w_do_pop)  r_rptr <= r_rptr + AW'(1);
      case ({w_do_push, w_do_pop})
        2'b10:   r_cnt <= r_cnt + (AW+1)'(1);
        2'b01:   r_cnt <= r_cnt - (AW+1)'(1);
        default: r_cnt <= r_cnt;
      endcase
    end
  end
endmodule

module uart_mmio #(
  parameter int CLOCK_FREQ = 125_000_000,
  parameter int BAUD_RATE  = 115_200,
  parameter int FIFO_DEPTH = 4
) (
  input  logic        clk,
  input  logic        n_rst,
  input  logic        sel,
  input  logic        we,
  input  logic [3:0]  addr,
  input  logic [31:0] wdata,
  input  logic [3:0]  byte_enable,
  output logic [31:0] rdata,
  output logic        uart_txd,
  input  logic        uart_rxd,
  output logic        rx_irq
);
  localparam int          DIV_INT = CLOCK_FREQ / BAUD_RATE;
  localparam logic [15:0] DIV_RST = DIV_INT[15:0];

  typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_t;
  typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP, RX_WAIT} rx_state_t;

  tx_state_t   r_tx_state, w_tx_nxt;
  rx_state_t   r_rx_state, w_rx_nxt;
  logic [15:0] r_div;
  logic [15:0] r_tx_cnt, r_rx_cnt;
  logic [2:0]  r_tx_bit, r_rx_bit;
  logic [7:0]  r_tx_shift, r_rx_shift;
  logic        r_txd, r_rx_s1, r_rx_s2, r_ovr, r_ferr;

  logic        w_wr, w_tx_push, w_tx_pop, w_rx_push, w_rx_pop, w_st_w1c;
  logic        w_tx_empty, w_tx_full, w_rx_empty, w_rx_full, w_tx_idle;
  logic        w_tx_tick, w_rx_tick, w_rxs, w_ovr_set, w_ferr_set;
  logic [7:0]  w_tx_head, w_rx_head;
  logic [15:0] w_div_m1, w_half_m1;
  logic        w_unused;

  assign w_unused  = ^{addr[1:0], wdata[31:16], byte_enable[3:1]};
  assign w_wr      = sel && we && byte_enable[0];
  assign w_tx_push = w_wr && (addr[3:2] == 2'd0) && !w_tx_full;
  assign w_rx_pop  = sel && !we && (addr[3:2] == 2'd0) && !w_rx_empty;
  assign w_st_w1c  = w_wr && (addr[3:2] == 2'd1);
  assign w_div_m1  = r_div - 16'd1;
  assign w_half_m1 = {1'b0, r_div[15:1]} - 16'd1;
  assign w_tx_tick = (r_tx_cnt == 16'd0);
  assign w_rx_tick = (r_rx_cnt == 16'd0);
  assign w_rxs     = r_rx_s2;
  assign w_tx_idle = w_tx_empty && (r_tx_state == TX_IDLE);
  assign uart_txd  = r_txd;
  assign rx_irq    = !w_rx_empty;

  uart_mmio_fifo #(.DEPTH(FIFO_DEPTH)) u_tx_fifo (
    .clk(clk), .n_rst(n_rst), .i_push(w_tx_push), .i_pop(w_tx_pop),
    .i_data(wdata[7:0]), .o_data(w_tx_head), .o_empty(w_tx_empty), .o_full(w_tx_full)
  );

  uart_mmio_fifo #(.DEPTH(FIFO_DEPTH)) u_rx_fifo (
    .clk(clk), .n_rst(n_rst), .i_push(w_rx_push), .i_pop(w_rx_pop),
    .i_data(r_rx_shift), .o_data(w_rx_head), .o_empty(w_rx_empty), .o_full(w_rx_full)
  );

  always_comb begin
    rdata = 32'd0;
    if (sel && !we) begin
      case (addr[3:2])
        2'd0:    rdata = {24'd0, w_rx_empty ? 8'h00 : w_rx_head};
        2'd1:    rdata = {27'd0, r_ferr, r_ovr, w_tx_idle, w_tx_full, !w_rx_empty};
        2'd2:    rdata = {16'd0, r_div};
        default: rdata = 32'd0;
      endcase
    end
  end

  // Register file: divisor and sticky flags; a set event outranks a W1C on the same edge.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_div  <= DIV_RST;
      r_ovr  <= 1'b0;
      r_ferr <= 1'b0;
    end else begin
      if (w_wr && (addr[3:2] == 2'd2))
        r_div <= (wdata[15:0] < 16'd4) ? 16'd4 : wdata[15:0];
      r_ovr  <= w_ovr_set  | (r_ovr  & ~(w_st_w1c & wdata[3]));
      r_ferr <= w_ferr_set | (r_ferr & ~(w_st_w1c & wdata[4]));
    end
  end

  // TX FSM
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) r_tx_state <= TX_IDLE;
    else        r_tx_state <= w_tx_nxt;
  end

  always_comb begin
    w_tx_nxt = r_tx_state;
    w_tx_pop = 1'b0;
    case (r_tx_state)
      TX_IDLE:  if (!w_tx_empty) begin
                  w_tx_pop = 1'b1;
                  w_tx_nxt = TX_START;
                end
      TX_START: if (w_tx_tick) w_tx_nxt = TX_DATA;
      TX_DATA:  if (w_tx_tick && (r_tx_bit == 3'd7)) w_tx_nxt = TX_STOP;
      TX_STOP:  if (w_tx_tick) begin
                  if (!w_tx_empty) begin
                    w_tx_pop = 1'b1;
                    w_tx_nxt = TX_START;
                  end else begin
                    w_tx_nxt = TX_IDLE;
                  end
                end
      default:  w_tx_nxt = TX_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_tx_cnt <= 16'd0;
      r_tx_bit <= 3'd0;
      r_txd    <= 1'b1;
    end else if (w_tx_pop) begin
      r_tx_cnt <= w_div_m1;
      r_txd    <= 1'b0;
    end else if (r_tx_state != TX_IDLE) begin
      if (w_tx_tick) begin
        r_tx_cnt <= w_div_m1;
        case (r_tx_state)
          TX_START: begin
            r_txd    <= r_tx_shift[0];
            r_tx_bit <= 3'd0;
          end
          TX_DATA: begin
            r_txd    <= (r_tx_bit == 3'd7) ? 1'b1 : r_tx_shift[1];
            r_tx_bit <= r_tx_bit + 3'd1;
          end
          default: r_txd <= 1'b1;
        endcase
      end else begin
        r_tx_cnt <= r_tx_cnt - 16'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_tx_pop)                              r_tx_shift <= w_tx_head;
    else if ((r_tx_state == TX_DATA) && w_tx_tick) r_tx_shift <= {1'b0, r_tx_shift[7:1]};
  end

  // RX synchronizer and FSM
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_rx_s1    <= 1'b1;
      r_rx_s2    <= 1'b1;
      r_rx_state <= RX_IDLE;
    end else begin
      r_rx_s1    <= uart_rxd;
      r_rx_s2    <= r_rx_s1;
      r_rx_state <= w_rx_nxt;
    end
  end

  always_comb begin
    w_rx_nxt   = r_rx_state;
    w_rx_push  = 1'b0;
    w_ovr_set  = 1'b0;
    w_ferr_set = 1'b0;
    case (r_rx_state)
      RX_IDLE:  if (!w_rxs) w_rx_nxt = RX_START;
      RX_START: if (w_rx_tick) w_rx_nxt = w_rxs ? RX_IDLE : RX_DATA;
      RX_DATA:  if (w_rx_tick && (r_rx_bit == 3'd7)) w_rx_nxt = RX_STOP;
      RX_STOP:  if (w_rx_tick) begin
                  if (w_rxs) begin
                    w_rx_nxt = RX_IDLE;
                    if (w_rx_full && !w_rx_pop) w_ovr_set = 1'b1;
                    else                        w_rx_push = 1'b1;
                  end else begin
                    w_ferr_set = 1'b1;
                    w_rx_nxt   = RX_WAIT;
                  end
                end
      RX_WAIT:  if (w_rxs) w_rx_nxt = RX_IDLE;
      default:  w_rx_nxt = RX_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_rx_cnt <= 16'd0;
      r_rx_bit <= 3'd0;
    end else begin
      case (r_rx_state)
        RX_IDLE: if (!w_rxs) r_rx_cnt <= w_half_m1;
        RX_START, RX_DATA, RX_STOP: begin
          r_rx_cnt <= w_rx_tick ? w_div_m1 : (r_rx_cnt - 16'd1);
          if ((r_rx_state == RX_START) && w_rx_tick) r_rx_bit <= 3'd0;
          if ((r_rx_state == RX_DATA) && w_rx_tick)  r_rx_bit <= r_rx_bit + 3'd1;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if ((r_rx_state == RX_DATA) && w_rx_tick) r_rx_shift <= {w_rxs, r_rx_shift[7:1]};
  end
endmodule
